// File: rtl/keccak_state_buffer.sv
// ----------------------------------------------------------------------------
// keccak_state_buffer
//
// Staging buffer for the Keccak sponge state. The core datapath writes the
// state in multi-word beats. The full state is then presented flat to the
// Keccak-f[1600] round unit. While a permutation runs, the state is locked.
// The permuted state is loaded back in a single cycle.
//
// Optional feature macro: KECCAK_STATE_READBACK_EN
//   When this macro is defined, a registered single-word readback port is
//   added (rd_index_i / rd_data_o).
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         asynchronous reset, active-high
//   clear_i       synchronous clear of state, fill map, error and FSM
//   wr_valid_i    write beat valid
//   wr_ready_o    buffer can accept a beat (low while locked)
//   wr_index_i    index of the first word in the beat
//   wr_data_i     beat data; word k in bits [k*WORD_W +: WORD_W]
//   start_i       request permutation (lock state)
//   perm_busy_o   state locked for the permutation engine
//   perm_done_i   engine finished; perm_state_i is valid
//   perm_state_i  permuted state from the engine
//   state_o       flat state; word i in bits [i*WORD_W +: WORD_W]
//   state_full_o  every word written since the last clear/reset
//   err_o         sticky error flag
//   rd_index_i    (readback only) word index to read
//   rd_data_o     (readback only) registered word, 1-cycle latency
// ----------------------------------------------------------------------------
module keccak_state_buffer #(
    parameter int WORD_W         = 32,
    parameter int NUM_WORDS      = 50,
    parameter int WORDS_PER_BEAT = 2,
    parameter int IDX_W          = $clog2(NUM_WORDS + WORDS_PER_BEAT)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clear_i,
    input  logic                             wr_valid_i,
    output logic                             wr_ready_o,
    input  logic [IDX_W-1:0]                 wr_index_i,
    input  logic [WORDS_PER_BEAT*WORD_W-1:0] wr_data_i,
    input  logic                             start_i,
    output logic                             perm_busy_o,
    input  logic                             perm_done_i,
    input  logic [NUM_WORDS*WORD_W-1:0]      perm_state_i,
    output logic [NUM_WORDS*WORD_W-1:0]      state_o,
    output logic                             state_full_o,
    output logic                             err_o
`ifdef KECCAK_STATE_READBACK_EN
    ,
    input  logic [IDX_W-1:0]                 rd_index_i,
    output logic [WORD_W-1:0]                rd_data_o
`endif
);

    localparam int STATE_W = NUM_WORDS * WORD_W;
    // One extra bit so that wr_index_i + k cannot wrap back into range.
    localparam int EXT_W   = IDX_W + 1;

    typedef enum logic [1:0] {
        FILL,
        FULL,
        LOCKED
    } fsm_t;

    fsm_t                 fsm_q, fsm_d;
    logic [STATE_W-1:0]   array_q;
    logic [NUM_WORDS-1:0] fill_q, fill_d, word_we;
    logic [STATE_W-1:0]   beat_wdata;
    logic                 err_q;
    logic                 accept;
    logic                 beat_oob;
    logic                 oob_err;
    logic                 start_err;

    // Ready/busy depend only on the registered state. This keeps the beat
    // decode free of any loop back through the next-state logic.
    assign wr_ready_o   = (fsm_q != LOCKED);
    assign perm_busy_o  = (fsm_q == LOCKED);
    assign accept       = wr_valid_i && wr_ready_o;
    assign state_o      = array_q;
    assign state_full_o = &fill_q;
    assign err_o        = err_q;

    // Beat decode. Each beat lane addresses wr_index_i + k. A lane that lands
    // past the last word is dropped and flagged. Such a lane must never alias
    // onto a low word.
    always_comb begin
        logic [EXT_W-1:0] beat_idx;
        word_we    = '0;
        beat_wdata = '0;
        beat_oob   = 1'b0;
        beat_idx   = '0;
        for (int k = 0; k < WORDS_PER_BEAT; k++) begin
            beat_idx = EXT_W'(wr_index_i) + EXT_W'(k);
            if (beat_idx < EXT_W'(NUM_WORDS)) begin
                for (int i = 0; i < NUM_WORDS; i++) begin
                    if (beat_idx == EXT_W'(i)) begin
                        word_we[i]                       = accept;
                        beat_wdata[i*WORD_W +: WORD_W]   = wr_data_i[k*WORD_W +: WORD_W];
                    end
                end
            end else begin
                beat_oob = 1'b1;
            end
        end
    end

    assign fill_d  = fill_q | word_we;
    assign oob_err = accept && beat_oob;

    // Next-state logic. clear_i overrides everything and returns to FILL.
    always_comb begin
        fsm_d     = fsm_q;
        start_err = 1'b0;
        case (fsm_q)
            FILL: begin
                if (start_i) begin
                    start_err = 1'b1;
                end
                if (&fill_d) begin
                    fsm_d = FULL;
                end
            end
            FULL: begin
                if (start_i) begin
                    fsm_d = LOCKED;
                end
            end
            LOCKED: begin
                if (perm_done_i) begin
                    fsm_d = FULL;
                end
            end
            default: fsm_d = FILL;
        endcase
        if (clear_i) begin
            fsm_d     = FILL;
            start_err = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q <= FILL;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // State array, fill map and sticky error. The permuted state is loaded
    // only while locked, so a perm_done_i after a clear is ignored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            array_q <= '0;
            fill_q  <= '0;
            err_q   <= 1'b0;
        end else if (clear_i) begin
            array_q <= '0;
            fill_q  <= '0;
            err_q   <= 1'b0;
        end else if ((fsm_q == LOCKED) && perm_done_i) begin
            array_q <= perm_state_i;
            fill_q  <= '1;
        end else begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (word_we[i]) begin
                    array_q[i*WORD_W +: WORD_W] <= beat_wdata[i*WORD_W +: WORD_W];
                end
            end
            fill_q <= fill_d;
            if (oob_err || start_err) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef KECCAK_STATE_READBACK_EN
    logic [WORD_W-1:0] rd_word;

    // Out-of-range read indices fall through to zero without flagging.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (rd_index_i == IDX_W'(i)) begin
                rd_word = array_q[i*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_o <= '0;
        end else begin
            rd_data_o <= rd_word;
        end
    end
`endif

endmodule

// File: doc/keccak_state_buffer.md
Name: keccak_state_buffer

Overview:
- Parametrised Keccak state staging buffer: collects the sponge state from the core datapath in multi-word beats and presents it flat to the permutation engine.
- Accepts the permuted state back from the engine in a single cycle.
- Adds over the previous single-purpose state register:
  - valid/ready write handshake
  - per-word fill tracking
  - a lock while the permutation runs
  - bounds-checked indexing
  - error flagging
  - optional registered readback
- Sits between the core-side write interface and the Keccak-f[1600] round unit.

Parameters:
- WORD_W, 32, width of one state word in bits.
- NUM_WORDS, 50, number of state words. NUM_WORDS*WORD_W is the state width; 1600 for Keccak-f[1600].
- WORDS_PER_BEAT, 2, consecutive words written per accepted beat (>=1).
- IDX_W, $clog2(NUM_WORDS+WORDS_PER_BEAT), width of the word index port.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- clear_i  in  1  synchronous clear of state, fill map, error and FSM.
- wr_valid_i  in  1  write beat valid.
- wr_ready_o  out  1  buffer can accept a beat.
- wr_index_i  in  IDX_W  index of the first word in the beat.
- wr_data_i  in  WORDS_PER_BEAT*WORD_W  beat data; word k in bits [k*WORD_W +: WORD_W] goes to word wr_index_i+k.
- start_i  in  1  request permutation (lock state).
- perm_busy_o  out  1  state locked for the permutation engine.
- perm_done_i  in  1  engine finished; perm_state_i is valid.
- perm_state_i  in  NUM_WORDS*WORD_W  permuted state from the engine.
- state_o  out  NUM_WORDS*WORD_W  flat state; word i in bits [i*WORD_W +: WORD_W].
- state_full_o  out  1  every word written since the last clear/reset.
- err_o  out  1  sticky error flag.

Behaviour:
- Reset (rst_i=1, asynchronous) puts the block in its initial condition:
  - all words 0, fill map 0, err_o=0
  - FSM=FILL, so wr_ready_o=1, perm_busy_o=0, state_full_o=0
- FSM states: FILL, FULL, LOCKED.
  - wr_ready_o=1 in FILL and FULL; 0 in LOCKED.
  - perm_busy_o=1 only in LOCKED.
- Beat acceptance:
  - A beat is accepted when wr_valid_i && wr_ready_o.
  - Words wr_index_i+k with index < NUM_WORDS are written on that edge and their fill bits set.
  - Words with index >= NUM_WORDS are dropped, never aliased or wrapped, and set err_o.
- state_full_o = AND of the fill map. It updates on the edge after the last missing word is written.
- FILL -> FULL on the edge where the fill map becomes complete.
- start_i handling:
  - In FULL: FULL -> LOCKED on the next edge. A beat accepted in the same cycle is applied before locking.
  - In FILL: start_i is ignored and sets err_o.
  - In LOCKED: start_i is ignored, no error.
- LOCKED -> FULL on perm_done_i:
  - The whole array is loaded from perm_state_i on that edge; fill map stays complete.
  - wr_ready_o rises the cycle after.
- perm_done_i outside LOCKED is ignored, no error.
- In FULL, accepted beats overwrite words in place (absorb of the next block). The fill map stays complete.
- wr_valid_i in LOCKED is back-pressured. The beat is held by the sender and not dropped or erroring.
- clear_i:
  - Takes priority over writes, start_i and perm_done_i.
  - On that edge: array=0, fill map=0, err_o=0, FSM=FILL.
  - If asserted during LOCKED, it abandons the permutation; a later perm_done_i is ignored.
- Reset mid-operation behaves like clear_i, but asynchronously.
- Timing: state_o is driven directly from the array registers, so it reflects a write one cycle after acceptance. No combinational path from wr_data_i to state_o.

Optional Feature:
- Macro: KECCAK_STATE_READBACK_EN.
- When defined, adds two ports:
  - rd_index_i  in  IDX_W
  - rd_data_o  out  WORD_W
- rd_data_o is registered: it equals word rd_index_i from the array as of the previous edge, so it has 1-cycle latency. It does not reflect a write on that same edge.
- rd_index_i >= NUM_WORDS returns 0 and does not set err_o.
- rd_data_o resets to 0.
- When undefined, the ports do not exist and no read mux or register is built.

Test Plan:
- Fill: after reset, 25 beats with index 0,2,...,48 and data {2i+1, 2i} -> state_full_o=1 exactly one cycle after the last beat; word 49 = 0x00000031; err_o=0.
- Bounds: beat at index 49, data {0xDEADBEEF, 0x12345678} -> word 49 = 0x12345678, nothing else written (no aliasing to word 0), err_o=1; clear_i then returns err_o=0.
- Lock: in FULL, start_i for 1 cycle -> perm_busy_o=1, wr_ready_o=0 next cycle. Hold wr_valid_i 5 cycles; no word changes. perm_done_i with perm_state_i=all 0xA5 -> state_o=all 0xA5, then the held beat is accepted.
- Simultaneous events:
  - Beat to index 0 plus start_i in the same FULL cycle -> word 0 updated and LOCKED.
  - clear_i with perm_done_i in LOCKED -> state_o=0, FILL.
- Misuse: start_i in FILL -> stays FILL, err_o=1. perm_done_i in FULL -> state unchanged.
- With KECCAK_STATE_READBACK_EN: write word 7 = 0xCAFEF00D, set rd_index_i=7 -> rd_data_o=0xCAFEF00D one cycle later; rd_index_i=60 -> 0.
